prg_frame_sched: RTL and testbench

- Frame-level controller for the primary ray generator (prg_top).
- Accepts camera updates from the host into a shadow register and applies them to the active camera only between frames.
- Issues the phase-aligned start pulse to prg_top and throttles it with an outstanding-ray credit counter fed by downstream retire pulses.
- Reports frame completion only once the generator is done and every issued ray has retired.

---
 rtl/prg_frame_sched_pkg.sv | 42 ++++
 rtl/prg_frame_sched_if.sv | 11 +
 rtl/prg_credit_cnt.sv | 51 +++++
 rtl/prg_frame_sched.sv | 117 +++++++++++
 tb/tb_prg_frame_sched.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/prg_frame_sched_pkg.sv
// rtl/prg_frame_sched_pkg.sv - shared ray-tracer types and frame-scheduler constants
package prg_frame_sched_pkg;

    typedef logic [31:0] float_t;

    typedef struct packed {
        float_t x;
        float_t y;
        float_t z;
    } vector_t;

    // Field order E,U,V,W,D,pw is relied on wherever a camera is packed/unpacked.
    typedef struct packed {
        vector_t E;
        vector_t U;
        vector_t V;
        vector_t W;
        float_t  D;
        float_t  pw;
    } camera_t;

    typedef struct packed {
        vector_t org;
        vector_t dir;
    } prg_ray_t;

    localparam int PRG_MAX_OUT = 64;
    localparam int PRG_SKID    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARM,
        ST_RUN,
        ST_DRAIN
    } sched_state_t;

    function automatic int cred_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/prg_frame_sched_if.sv
// rtl/prg_frame_sched_if.sv - host camera packet handshake
interface prg_frame_sched_if;
    import prg_frame_sched_pkg::*;

    logic    cam_valid;
    logic    cam_ready;
    camera_t cam_in;

    modport master (output cam_valid, output cam_in, input cam_ready);
    modport slave  (input cam_valid, input cam_in, output cam_ready);
endinterface

// File: rtl/prg_credit_cnt.sv
// rtl/prg_credit_cnt.sv - outstanding-item credit counter with early stall and sticky error
module prg_credit_cnt
    import prg_frame_sched_pkg::*;
#(
    parameter int MAX_OUT = PRG_MAX_OUT,
    parameter int SKID    = PRG_SKID,
    parameter int CW      = $clog2(PRG_MAX_OUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          stall,
    output logic          err
);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
    localparam logic [CW-1:0] TH_C  = CW'(MAX_OUT - SKID);

    logic [CW-1:0] cnt_d;
    logic          err_d;

    always_comb begin
        cnt_d = count;
        err_d = err;
        case ({inc, dec})
            2'b10: begin
                if (count == MAX_C) err_d = 1'b1;
                else                cnt_d = count + 1'b1;
            end
            2'b01: begin
                if (count == '0) err_d = 1'b1;
                else             cnt_d = count - 1'b1;
            end
            default: ;
        endcase
    end

    // Stall is registered from the next count so it tracks the visible count exactly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
            stall <= 1'b0;
            err   <= 1'b0;
        end else begin
            count <= cnt_d;
            stall <= (cnt_d >= TH_C);
            err   <= err_d;
        end
    end
endmodule

// File: rtl/prg_frame_sched.sv
// rtl/prg_frame_sched.sv - frame controller for prg_top: camera shadowing, start, credits, completion
module prg_frame_sched
    import prg_frame_sched_pkg::*;
#(
    parameter int MAX_OUT = PRG_MAX_OUT,
    parameter int SKID    = PRG_SKID,
    parameter int FCW     = 16
) (
    input  logic                clk,
    input  logic                rst,
    prg_frame_sched_if.slave    cam,
    input  logic                frame_req,
    input  logic                cont_mode,
    input  logic                v1,
    output vector_t             E,
    output vector_t             U,
    output vector_t             V,
    output vector_t             W,
    output float_t              D,
    output float_t              pw,
    output logic                prg_start,
    input  logic                prg_idle,
    input  logic                prg_done,
    input  logic                prg_ray_valid,
    input  logic                ray_retire,
    output logic                prg_stall,
    output logic                frame_busy,
    output logic                frame_done,
    output logic [FCW-1:0]      frame_cnt,
    output logic                cred_err
);
    localparam int CW = cred_width(MAX_OUT);

    sched_state_t  state, state_d;
    camera_t       shadow_q, active_q;
    logic          pending, have_cam;
    logic [CW-1:0] outstanding;
    logic          accept;

    assign cam.cam_ready = ~pending;
    assign accept        = cam.cam_valid & ~pending;

    assign E  = active_q.E;
    assign U  = active_q.U;
    assign V  = active_q.V;
    assign W  = active_q.W;
    assign D  = active_q.D;
    assign pw = active_q.pw;

    assign frame_busy = (state != ST_IDLE);

    prg_credit_cnt #(
        .MAX_OUT (MAX_OUT),
        .SKID    (SKID),
        .CW      (CW)
    ) u_cred (
        .clk   (clk),
        .rst   (rst),
        .inc   (prg_ray_valid),
        .dec   (ray_retire),
        .count (outstanding),
        .stall (prg_stall),
        .err   (cred_err)
    );

    always_comb begin
        state_d    = state;
        prg_start  = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if ((frame_req || cont_mode) && (pending || have_cam)) state_d = ST_LOAD;
            end
            ST_LOAD: state_d = ST_ARM;
            ST_ARM: begin
                if (v1 && prg_idle) begin
                    prg_start = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (prg_done) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (outstanding == '0) begin
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Accept needs pending==0 and LOAD copy needs pending==1, so they never collide.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            shadow_q  <= '0;
            active_q  <= '0;
            pending   <= 1'b0;
            have_cam  <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_d;
            if (accept) begin
                shadow_q <= cam.cam_in;
                pending  <= 1'b1;
            end
            if (state == ST_LOAD && pending) begin
                active_q <= shadow_q;
                pending  <= 1'b0;
                have_cam <= 1'b1;
            end
            if (frame_done) frame_cnt <= frame_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_prg_frame_sched.sv
// tb/tb_prg_frame_sched.sv - directed self-checking bench for prg_frame_sched
module tb_prg_frame_sched;
    import prg_frame_sched_pkg::*;

    localparam int FCW = 16;

    logic clk = 1'b0;
    logic rst, frame_req, cont_mode, v1, prg_idle, prg_done, prg_ray_valid, ray_retire;
    logic prg_start, prg_stall, frame_busy, frame_done, cred_err;
    logic [FCW-1:0] frame_cnt;
    vector_t E, U, V, W;
    float_t  D, pw;
    camera_t act_cam;
    camera_t c_zero, c1, c2, c3;

    int n_tests = 0;
    int n_fail  = 0;
    int ph      = 0;

    prg_frame_sched_if cam_if ();

    prg_frame_sched #(.MAX_OUT(64), .SKID(4), .FCW(FCW)) dut (
        .clk(clk), .rst(rst), .cam(cam_if), .frame_req(frame_req), .cont_mode(cont_mode),
        .v1(v1), .E(E), .U(U), .V(V), .W(W), .D(D), .pw(pw), .prg_start(prg_start),
        .prg_idle(prg_idle), .prg_done(prg_done), .prg_ray_valid(prg_ray_valid),
        .ray_retire(ray_retire), .prg_stall(prg_stall), .frame_busy(frame_busy),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .cred_err(cred_err)
    );

    assign act_cam = {E, U, V, W, D, pw};

    always #5 clk = ~clk;

    // One clock; v1 models the 3-phase counter, high every third cycle.
    task automatic step();
        @(posedge clk);
        #1;
        ph = (ph == 2) ? 0 : ph + 1;
        v1 = (ph == 0);
        #1;
    endtask

    task automatic wait_start(input string tag);
        int found = 0;
        for (int i = 0; i < 8; i++) begin
            if (prg_start === 1'b1) begin
                found = 1;
                break;
            end
            step();
        end
        n_tests++;
        if (found != 1) begin n_fail++; $display("FAIL %s_start_timeout got=%0d exp=1", tag, found); end
        if (found == 1) begin
            n_tests++;
            if (v1 !== 1'b1) begin n_fail++; $display("FAIL %s_start_v1 got=%b exp=1", tag, v1); end
            step();
            n_tests++;
            if (prg_start !== 1'b0) begin n_fail++; $display("FAIL %s_start_width got=%b exp=0", tag, prg_start); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(); step();
        n_tests++; if (act_cam !== c_zero) begin n_fail++; $display("FAIL reset_cam got=%h exp=0", act_cam); end
        n_tests++; if (cam_if.cam_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cam_ready got=%b exp=1", cam_if.cam_ready); end
        n_tests++; if ({prg_start, prg_stall, frame_busy, frame_done, cred_err} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=00000", {prg_start, prg_stall, frame_busy, frame_done, cred_err}); end
        n_tests++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_frame_cnt got=%0d exp=0", frame_cnt); end
        rst = 1'b1;
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        step();
        n_tests++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL req_no_cam got=%b exp=0", frame_busy); end
    endtask

    task automatic test_cam_frame();
        cam_if.cam_in    = c1;
        cam_if.cam_valid = 1'b1;
        #1;
        n_tests++; if (cam_if.cam_ready !== 1'b1) begin n_fail++; $display("FAIL cam_ready_idle got=%b exp=1", cam_if.cam_ready); end
        step();
        cam_if.cam_valid = 1'b0;
        n_tests++; if (cam_if.cam_ready !== 1'b0) begin n_fail++; $display("FAIL cam_ready_pending got=%b exp=0", cam_if.cam_ready); end
        n_tests++; if (act_cam !== c_zero) begin n_fail++; $display("FAIL cam_early_apply got=%h exp=0", act_cam); end
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        n_tests++; if (frame_busy !== 1'b1) begin n_fail++; $display("FAIL load_busy got=%b exp=1", frame_busy); end
        n_tests++; if (act_cam !== c_zero) begin n_fail++; $display("FAIL load_cycle_cam got=%h exp=0", act_cam); end
        step();
        n_tests++; if (act_cam !== c1) begin n_fail++; $display("FAIL load_cam got=%h exp=%h", act_cam, c1); end
        n_tests++; if (cam_if.cam_ready !== 1'b1) begin n_fail++; $display("FAIL cam_ready_after_load got=%b exp=1", cam_if.cam_ready); end
        wait_start("f1");
    endtask

    task automatic test_stall();
        prg_ray_valid = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (i == 59) begin
                n_tests++; if (prg_stall !== 1'b0) begin n_fail++; $display("FAIL stall_at_59 got=%b exp=0", prg_stall); end
            end
            if (i == 60) begin
                n_tests++; if (prg_stall !== 1'b1) begin n_fail++; $display("FAIL stall_at_60 got=%b exp=1", prg_stall); end
            end
        end
        prg_ray_valid = 1'b0;
        ray_retire    = 1'b1;
        step();
        n_tests++; if (prg_stall !== 1'b0) begin n_fail++; $display("FAIL stall_drop_59 got=%b exp=0", prg_stall); end
        for (int i = 0; i < 54; i++) step();
        ray_retire = 1'b0;
        n_tests++; if (cred_err !== 1'b0) begin n_fail++; $display("FAIL cred_err_normal got=%b exp=0", cred_err); end
    endtask

    task automatic test_drain();
        prg_done = 1'b1;
        step();
        prg_done = 1'b0;
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL drain_early got=%b exp=0", frame_done); end
        for (int i = 1; i <= 5; i++) begin
            ray_retire = 1'b1;
            step();
            ray_retire = 1'b0;
            n_tests++; if (frame_done !== (i == 5)) begin n_fail++; $display("FAIL drain_retire%0d got=%b exp=%b", i, frame_done, (i == 5)); end
        end
        n_tests++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL cnt_before_done got=%0d exp=0", frame_cnt); end
        step();
        n_tests++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL cnt_after_done got=%0d exp=1", frame_cnt); end
        n_tests++; if ({frame_done, frame_busy} !== 2'b00) begin n_fail++; $display("FAIL post_done_idle got=%b exp=00", {frame_done, frame_busy}); end
    endtask

    task automatic test_midframe_cam();
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        step();
        n_tests++; if (act_cam !== c1) begin n_fail++; $display("FAIL reuse_cam got=%h exp=%h", act_cam, c1); end
        wait_start("f2");
        cam_if.cam_in    = c2;
        cam_if.cam_valid = 1'b1;
        step();
        n_tests++; if (cam_if.cam_ready !== 1'b0) begin n_fail++; $display("FAIL mid_push_ready got=%b exp=0", cam_if.cam_ready); end
        cam_if.cam_in = c3;
        frame_req     = 1'b1;
        step(); step();
        frame_req        = 1'b0;
        cam_if.cam_valid = 1'b0;
        n_tests++; if (act_cam !== c1) begin n_fail++; $display("FAIL mid_push_active got=%h exp=%h", act_cam, c1); end
        n_tests++; if (cam_if.cam_ready !== 1'b0) begin n_fail++; $display("FAIL second_push_ready got=%b exp=0", cam_if.cam_ready); end
        prg_done = 1'b1;
        step();
        prg_done = 1'b0;
        n_tests++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL f2_done got=%b exp=1", frame_done); end
        step(); step();
        n_tests++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL busy_req_queued got=%b exp=0", frame_busy); end
        n_tests++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL f2_cnt got=%0d exp=2", frame_cnt); end
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        step();
        n_tests++; if (act_cam !== c2) begin n_fail++; $display("FAIL next_load_cam got=%h exp=%h", act_cam, c2); end
        n_tests++; if (cam_if.cam_ready !== 1'b1) begin n_fail++; $display("FAIL next_load_ready got=%b exp=1", cam_if.cam_ready); end
        wait_start("f3");
    endtask

    task automatic test_credit_edges();
        prg_ray_valid = 1'b1;
        for (int i = 0; i < 10; i++) step();
        ray_retire = 1'b1;
        step();
        prg_ray_valid = 1'b0;
        ray_retire    = 1'b0;
        prg_done      = 1'b1;
        step();
        prg_done = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            ray_retire = 1'b1;
            step();
            ray_retire = 1'b0;
            if (i >= 9) begin
                n_tests++; if (frame_done !== (i == 10)) begin n_fail++; $display("FAIL simul_retire%0d got=%b exp=%b", i, frame_done, (i == 10)); end
            end
        end
        step();
        n_tests++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL f3_cnt got=%0d exp=3", frame_cnt); end
        n_tests++; if (cred_err !== 1'b0) begin n_fail++; $display("FAIL cred_err_simul got=%b exp=0", cred_err); end
        ray_retire = 1'b1;
        step();
        ray_retire = 1'b0;
        n_tests++; if (cred_err !== 1'b1) begin n_fail++; $display("FAIL underflow_err got=%b exp=1", cred_err); end
        n_tests++; if (prg_stall !== 1'b0) begin n_fail++; $display("FAIL underflow_wrap got=%b exp=0", prg_stall); end
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        step();
        wait_start("f4");
        prg_done = 1'b1;
        step();
        prg_done = 1'b0;
        n_tests++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL underflow_held_zero got=%b exp=1", frame_done); end
        step();
        n_tests++; if (frame_cnt !== 16'd4) begin n_fail++; $display("FAIL f4_cnt got=%0d exp=4", frame_cnt); end
        n_tests++; if (cred_err !== 1'b1) begin n_fail++; $display("FAIL cred_err_sticky got=%b exp=1", cred_err); end
    endtask

    task automatic test_reset_midframe();
        int seen = 0;
        frame_req = 1'b1;
        step();
        frame_req = 1'b0;
        step();
        wait_start("f5");
        prg_ray_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        prg_ray_valid = 1'b0;
        rst = 1'b0;
        step();
        rst = 1'b1;
        n_tests++; if (act_cam !== c_zero) begin n_fail++; $display("FAIL midrst_cam got=%h exp=0", act_cam); end
        n_tests++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_cnt got=%0d exp=0", frame_cnt); end
        n_tests++; if ({frame_busy, cred_err, prg_stall, cam_if.cam_ready} !== 4'b0001) begin
            n_fail++; $display("FAIL midrst_flags got=%b exp=0001", {frame_busy, cred_err, prg_stall, cam_if.cam_ready}); end
        prg_done  = 1'b1;
        frame_req = 1'b1;
        step();
        prg_done  = 1'b0;
        frame_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (frame_done === 1'b1) seen++;
            step();
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL midrst_done_pulses got=%0d exp=0", seen); end
        n_tests++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_req_dropped got=%b exp=0", frame_busy); end
    endtask

    task automatic test_cont_mode();
        int nstart    = 0;
        int ndone     = 0;
        int done_next = 0;
        cam_if.cam_in    = c1;
        cam_if.cam_valid = 1'b1;
        step();
        cam_if.cam_valid = 1'b0;
        cont_mode        = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            prg_done  = (done_next == 1);
            done_next = 0;
            if (prg_start === 1'b1) begin
                nstart++;
                done_next = 1;
                n_tests++; if (v1 !== 1'b1) begin n_fail++; $display("FAIL cont_start%0d_v1 got=%b exp=1", nstart, v1); end
            end
            if (frame_done === 1'b1) begin
                ndone++;
                if (ndone == 3) begin
                    cont_mode = 1'b0;
                    break;
                end
            end
        end
        prg_done  = 1'b0;
        cont_mode = 1'b0;
        n_tests++; if (ndone != 3) begin n_fail++; $display("FAIL cont_done_pulses got=%0d exp=3", ndone); end
        step(); step(); step();
        n_tests++; if (frame_busy !== 1'b0) begin n_fail++; $display("FAIL cont_stop got=%b exp=0", frame_busy); end
        n_tests++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL cont_cnt got=%0d exp=3", frame_cnt); end
        n_tests++; if (nstart != 3) begin n_fail++; $display("FAIL cont_starts got=%0d exp=3", nstart); end
        n_tests++; if (act_cam !== c1) begin n_fail++; $display("FAIL cont_cam got=%h exp=%h", act_cam, c1); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        c_zero = '0;
        c1 = '{E: '{32'h0, 32'h0, 32'h0},
               U: '{32'h3F800000, 32'h0, 32'h0},
               V: '{32'h0, 32'h3F800000, 32'h0},
               W: '{32'h0, 32'h0, 32'h3F800000},
               D: 32'h42C80000, pw: 32'h3F800000};
        c2 = '{E: '{32'h40000000, 32'h40400000, 32'h40800000},
               U: '{32'h0, 32'h3F800000, 32'h0},
               V: '{32'h0, 32'h0, 32'h3F800000},
               W: '{32'h3F800000, 32'h0, 32'h0},
               D: 32'h41200000, pw: 32'h3F000000};
        c3 = '{E: '{32'hBF800000, 32'h0, 32'h0},
               U: '{32'h0, 32'h0, 32'hBF800000},
               V: '{32'h0, 32'hBF800000, 32'h0},
               W: '{32'hBF800000, 32'h0, 32'h0},
               D: 32'h3F800000, pw: 32'h40000000};
        rst = 1'b0; frame_req = 1'b0; cont_mode = 1'b0; v1 = 1'b0; prg_idle = 1'b1;
        prg_done = 1'b0; prg_ray_valid = 1'b0; ray_retire = 1'b0;
        cam_if.cam_valid = 1'b0; cam_if.cam_in = '0;

        test_reset();
        test_cam_frame();
        test_stall();
        test_drain();
        test_midframe_cam();
        test_credit_edges();
        test_reset_midframe();
        test_cont_mode();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
